// File: rtl/alu_pkg.sv
// Shared constants for the iterative ALU: FunSel codes, flag bit positions
// and the controller state encoding.
package alu_pkg;

  localparam logic [3:0] OP_PASSA = 4'd0;
  localparam logic [3:0] OP_PASSB = 4'd1;
  localparam logic [3:0] OP_NOTA  = 4'd2;
  localparam logic [3:0] OP_NOTB  = 4'd3;
  localparam logic [3:0] OP_ADD   = 4'd4;
  localparam logic [3:0] OP_ADC   = 4'd5;
  localparam logic [3:0] OP_SUB   = 4'd6;
  localparam logic [3:0] OP_AND   = 4'd7;
  localparam logic [3:0] OP_OR    = 4'd8;
  localparam logic [3:0] OP_XOR   = 4'd9;
  localparam logic [3:0] OP_NAND  = 4'd10;
  localparam logic [3:0] OP_LSL   = 4'd11;
  localparam logic [3:0] OP_LSR   = 4'd12;
  localparam logic [3:0] OP_ASR   = 4'd13;
  localparam logic [3:0] OP_CSL   = 4'd14;
  localparam logic [3:0] OP_CSR   = 4'd15;

  localparam logic [5:0] FS_MULU = 6'b100000;
  localparam logic [5:0] FS_DIVU = 6'b100001;

  localparam int FLAG_Z = 3;
  localparam int FLAG_C = 2;
  localparam int FLAG_N = 1;
  localparam int FLAG_O = 0;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ITER = 2'd1,
    ST_DONE = 2'd2
  } alu_state_e;

endpackage

// File: rtl/alu_muldiv_seq.sv
// Bit-serial unsigned multiply / restoring divide. The first step is taken
// on the start edge, so WIDTH steps are complete once count reaches WIDTH.
module alu_muldiv_seq
  import alu_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             start_i,
  input  logic             div_i,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  output logic             busy_o,
  output logic             done_o,
  output logic [WIDTH-1:0] lo_o,
  output logic [WIDTH-1:0] hi_o
);

  localparam int CW = $clog2(WIDTH + 1);

  logic             busy_q;
  logic             div_q;
  logic [CW-1:0]    count_q;
  logic [WIDTH-1:0] lo_q;
  logic [WIDTH-1:0] hi_q;
  logic [WIDTH-1:0] b_q;

  // One iteration on {hi, lo}. Multiply: lo holds the multiplier and is
  // shifted out while the partial product shifts in from hi. Divide: lo holds
  // the dividend shifting into the remainder while quotient bits shift in.
  function automatic logic [2*WIDTH-1:0] step(input logic             div,
                                               input logic [WIDTH-1:0] hi,
                                               input logic [WIDTH-1:0] lo,
                                               input logic [WIDTH-1:0] b);
    logic [WIDTH:0]     acc;
    logic [2*WIDTH-1:0] res;
    if (!div) begin
      acc = {1'b0, hi} + (lo[0] ? {1'b0, b} : {(WIDTH+1){1'b0}});
      res = {acc[WIDTH:1], acc[0], lo[WIDTH-1:1]};
    end else begin
      acc = {hi, lo[WIDTH-1]} - {1'b0, b};
      if (!acc[WIDTH]) begin
        res = {acc[WIDTH-1:0], lo[WIDTH-2:0], 1'b1};
      end else begin
        res = {hi[WIDTH-2:0], lo[WIDTH-1], lo[WIDTH-2:0], 1'b0};
      end
    end
    return res;
  endfunction

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      busy_q  <= 1'b0;
      div_q   <= 1'b0;
      count_q <= '0;
      lo_q    <= '0;
      hi_q    <= '0;
      b_q     <= '0;
    end else if (start_i) begin
      busy_q       <= 1'b1;
      div_q        <= div_i;
      b_q          <= b_i;
      count_q      <= CW'(1);
      {hi_q, lo_q} <= step(div_i, '0, a_i, b_i);
    end else if (busy_q) begin
      if (count_q == CW'(WIDTH)) begin
        busy_q <= 1'b0;
      end else begin
        count_q      <= count_q + CW'(1);
        {hi_q, lo_q} <= step(div_q, hi_q, lo_q, b_q);
      end
    end
  end

  assign busy_o = busy_q;
  assign done_o = busy_q && (count_q == CW'(WIDTH));
  assign lo_o   = lo_q;
  assign hi_o   = hi_q;

endmodule

// File: rtl/iterative_alu.sv
// Multi-function ALU: single-cycle logic/arith/shift ops in HALF or full
// width, plus bit-serial MULU/DIVU delegated to alu_muldiv_seq.
//
// Handshake: a request is accepted on a rising Clock edge where Start=1 and
// Ready=1; A, B, FunSel and WF are captured there. Done pulses for one cycle
// with the result, which then holds until the next Done.
module iterative_alu
  import alu_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int HALF  = WIDTH / 2
) (
  input  logic             Clock,
  input  logic             Reset,
  input  logic             Start,
  input  logic [5:0]       FunSel,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             WF,
  output logic             Ready,
  output logic             Done,
  output logic [WIDTH-1:0] ALUOut,
  output logic [WIDTH-1:0] ALUOutHi,
  output logic [3:0]       FlagsOut,
  output alu_state_e       DbgState,
  output logic             DbgBusy
);

  localparam logic [WIDTH-1:0] FULL_MASK = '1;
  localparam logic [WIDTH-1:0] HALF_MASK = {{(WIDTH-HALF){1'b0}}, {HALF{1'b1}}};
  localparam logic [WIDTH-1:0] FULL_MSB  = {1'b1, {(WIDTH-1){1'b0}}};
  localparam logic [WIDTH-1:0] HALF_MSB  = {{(WIDTH-HALF){1'b0}}, 1'b1, {(HALF-1){1'b0}}};

  alu_state_e       state_q;
  logic             done_q;
  logic [WIDTH-1:0] out_q;
  logic [WIDTH-1:0] outhi_q;
  logic [3:0]       flags_q;
  logic             wf_q;
  logic             div_q;

  logic             ready_w;
  logic             accept_w;
  logic             is_mulu_w;
  logic             is_divu_w;
  logic             iter_start_w;
  logic             seq_done_w;
  logic             seq_busy_w;
  logic [WIDTH-1:0] seq_lo_w;
  logic [WIDTH-1:0] seq_hi_w;

  assign ready_w      = (state_q == ST_IDLE) || (state_q == ST_DONE);
  assign accept_w     = Start && ready_w;
  assign is_mulu_w    = (FunSel == FS_MULU);
  assign is_divu_w    = (FunSel == FS_DIVU);
  assign iter_start_w = accept_w && (is_mulu_w || (is_divu_w && (B != '0)));

  alu_muldiv_seq #(.WIDTH(WIDTH)) u_seq (
    .clk_i   (Clock),
    .rst_ni  (Reset),
    .start_i (iter_start_w),
    .div_i   (is_divu_w),
    .a_i     (A),
    .b_i     (B),
    .busy_o  (seq_busy_w),
    .done_o  (seq_done_w),
    .lo_o    (seq_lo_w),
    .hi_o    (seq_hi_w)
  );

  // Single-cycle datapath. Operands are masked to the effective width so the
  // upper half is zero in HALF mode; msb selects the effective sign bit.
  logic [WIDTH-1:0] mask, msb, a_e, b_e, alu_res;
  logic [WIDTH:0]   sum;
  logic [3:0]       alu_flags;
  logic             cin, a_s, b_s, r_s;

  always_comb begin
    mask      = FunSel[4] ? FULL_MASK : HALF_MASK;
    msb       = FunSel[4] ? FULL_MSB : HALF_MSB;
    a_e       = A & mask;
    b_e       = B & mask;
    cin       = flags_q[FLAG_C];
    a_s       = |(a_e & msb);
    b_s       = |(b_e & msb);
    sum       = '0;
    alu_res   = '0;
    alu_flags = flags_q;
    case (FunSel[3:0])
      OP_PASSA: alu_res = a_e;
      OP_PASSB: alu_res = b_e;
      OP_NOTA:  alu_res = ~a_e & mask;
      OP_NOTB:  alu_res = ~b_e & mask;
      OP_ADD, OP_ADC: begin
        sum = {1'b0, a_e} + {1'b0, b_e}
            + {{WIDTH{1'b0}}, (FunSel[3:0] == OP_ADC) && cin};
        alu_res           = sum[WIDTH-1:0] & mask;
        alu_flags[FLAG_C] = FunSel[4] ? sum[WIDTH] : sum[HALF];
      end
      OP_SUB: begin
        sum               = {1'b0, a_e} - {1'b0, b_e};
        alu_res           = sum[WIDTH-1:0] & mask;
        alu_flags[FLAG_C] = (a_e < b_e);
      end
      OP_AND:  alu_res = a_e & b_e;
      OP_OR:   alu_res = a_e | b_e;
      OP_XOR:  alu_res = a_e ^ b_e;
      OP_NAND: alu_res = ~(a_e & b_e) & mask;
      OP_LSL: begin
        alu_res           = (a_e << 1) & mask;
        alu_flags[FLAG_C] = a_s;
      end
      OP_LSR: begin
        alu_res           = a_e >> 1;
        alu_flags[FLAG_C] = a_e[0];
      end
      OP_ASR: begin
        alu_res           = (a_e >> 1) | (a_e & msb);
        alu_flags[FLAG_C] = a_e[0];
      end
      OP_CSL: begin
        alu_res           = ((a_e << 1) | {{(WIDTH-1){1'b0}}, cin}) & mask;
        alu_flags[FLAG_C] = a_s;
      end
      OP_CSR: begin
        alu_res           = (a_e >> 1) | (cin ? msb : '0);
        alu_flags[FLAG_C] = a_e[0];
      end
      default: alu_res = '0;
    endcase
    r_s               = |(alu_res & msb);
    alu_flags[FLAG_Z] = (alu_res == '0);
    alu_flags[FLAG_N] = r_s;
    if (FunSel[3:0] == OP_ADD || FunSel[3:0] == OP_ADC) begin
      alu_flags[FLAG_O] = (a_s == b_s) && (r_s != a_s);
    end else if (FunSel[3:0] == OP_SUB) begin
      alu_flags[FLAG_O] = (a_s != b_s) && (r_s != a_s);
    end
  end

  logic [3:0] iter_flags, div0_flags;

  always_comb begin
    iter_flags         = flags_q;
    iter_flags[FLAG_N] = 1'b0;
    if (div_q) begin
      iter_flags[FLAG_Z] = (seq_lo_w == '0);
      iter_flags[FLAG_C] = 1'b0;
    end else begin
      iter_flags[FLAG_Z] = ({seq_hi_w, seq_lo_w} == '0);
      iter_flags[FLAG_C] = (seq_hi_w != '0);
      iter_flags[FLAG_O] = (seq_hi_w != '0);
    end
    // Divide by zero yields an all-ones quotient, so Z is always clear.
    div0_flags         = flags_q;
    div0_flags[FLAG_Z] = 1'b0;
    div0_flags[FLAG_N] = 1'b0;
    div0_flags[FLAG_C] = 1'b1;
  end

  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      state_q <= ST_IDLE;
      done_q  <= 1'b0;
      out_q   <= '0;
      outhi_q <= '0;
      flags_q <= '0;
      wf_q    <= 1'b0;
      div_q   <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        ST_IDLE, ST_DONE: begin
          state_q <= ST_IDLE;
          if (accept_w) begin
            if (!FunSel[5]) begin
              state_q <= ST_DONE;
              done_q  <= 1'b1;
              out_q   <= alu_res;
              outhi_q <= '0;
              if (WF) flags_q <= alu_flags;
            end else if (iter_start_w) begin
              state_q <= ST_ITER;
              wf_q    <= WF;
              div_q   <= is_divu_w;
            end else if (is_divu_w) begin
              state_q <= ST_DONE;
              done_q  <= 1'b1;
              out_q   <= '1;
              outhi_q <= A;
              if (WF) flags_q <= div0_flags;
            end else begin
              state_q <= ST_DONE;
              done_q  <= 1'b1;
              out_q   <= '0;
              outhi_q <= '0;
            end
          end
        end
        ST_ITER: begin
          if (seq_done_w) begin
            state_q <= ST_DONE;
            done_q  <= 1'b1;
            out_q   <= seq_lo_w;
            outhi_q <= seq_hi_w;
            if (wf_q) flags_q <= iter_flags;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign Ready    = ready_w;
  assign Done     = done_q;
  assign ALUOut   = out_q;
  assign ALUOutHi = outhi_q;
  assign FlagsOut = flags_q;
  assign DbgState = state_q;
  assign DbgBusy  = seq_busy_w;

endmodule
